mario_power_fsm: RTL and testbench
==================================

Name: mario_power_fsm

Overview:
- Consumes the one-cycle touch pulse from the flower power-up object and the enemy-collision pulse. Owns the character power state: SMALL, GROW, FIRE and DEAD.
- Drives the post-hit invulnerability timer, the sprite blink and freeze signals for the renderer, and fireball spawn requests.
- Sits between the object collision stage and the character sprite/render stage.

Parameters:
- GROW_FRAMES, 30, frames spent in the GROW animation; game is frozen for this period.
- INVULN_FRAMES, 120, frames of invulnerability after a FIRE-to-SMALL hit.
- FIRE_COOLDOWN, 20, minimum frames between fireball requests.
- BLINK_PERIOD, 4, frames per blink half-phase while invulnerable.

Ports:
- sys_clk  in  1  system clock.
- RST  in  1  synchronous, active-high reset, sampled on rising sys_clk.
- frame_tick  in  1  one-cycle pulse per video frame; all timers count on it.
- touch_flower  in  1  one-cycle pulse when the character touches the flower.
- touch_enemy  in  1  one-cycle pulse when the character collides with an enemy.
- fire_btn  in  1  fire button, level, already synchronised.
- facing_right  in  1  character facing direction.
- char_X  in  10  character world X.
- char_Y  in  10  character world Y.
- fb_busy  in  1  a fireball is already in flight.
- power_state  out  2  0=SMALL, 1=GROW, 2=FIRE, 3=DEAD.
- char_height  out  5  sprite height: 12 when SMALL, 24 when FIRE or GROW.
- freeze  out  1  high in GROW; the game engine halts world motion.
- invuln  out  1  invulnerability timer is nonzero.
- char_visible  out  1  sprite draw enable, used for blink.
- dead  out  1  high in DEAD.
- fb_req  out  1  one-cycle fireball spawn pulse.
- fb_x  out  10  fireball spawn X.
- fb_y  out  10  fireball spawn Y.
- fb_dir  out  1  fireball direction, 1 = right.

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=SMALL; all timers 0; blink phase 0.
  - Outputs: power_state=0, char_height=12, freeze=0, invuln=0, char_visible=1, dead=0, fb_req=0, fb_x=0, fb_y=0, fb_dir=0.
  - Reset mid-GROW or mid-invulnerability aborts immediately; no residual timers.
- Event sampling: touch_flower and touch_enemy are sampled every cycle. State changes take effect at the same edge, with 1-cycle registered latency to the outputs.
- Timers decrement only on frame_tick and saturate at 0.
- SMALL:
  - touch_enemy with invuln=0 -> DEAD.
  - touch_flower -> GROW; grow timer loads GROW_FRAMES.
  - Simultaneous touch_enemy & touch_flower with invuln=0: enemy wins -> DEAD; the flower pulse is discarded.
  - If invuln=1, the enemy is ignored and the flower is taken.
- GROW:
  - freeze=1.
  - All touch_enemy and touch_flower pulses are ignored.
  - The invuln timer is held, not decremented.
  - When the grow timer reaches 0 on a frame_tick -> FIRE.
- FIRE:
  - touch_enemy with invuln=0 -> SMALL; invuln timer loads INVULN_FRAMES; cooldown cleared.
  - touch_flower is ignored; the flower object is consumed regardless.
- DEAD:
  - Sticky until RST.
  - All inputs ignored; dead=1, char_visible=1, fb_req=0.
- Invulnerability:
  - invuln = (timer != 0).
  - Blink phase toggles every BLINK_PERIOD frame_ticks while invuln=1.
  - char_visible = !(invuln & phase).
  - When the timer hits 0, the phase resets to 0.
- Fireball (FIRE state only):
  - Rising edge of fire_btn, detected with an internal 1-cycle delayed copy.
  - A request fires when the edge occurs with cooldown=0 and fb_busy=0.
  - On a request: fb_req pulses for 1 cycle; cooldown loads FIRE_COOLDOWN.
  - fb_dir=facing_right; fb_y=char_Y+4.
  - fb_x=char_X+12 when facing right, char_X-4 when facing left.
  - All fb_x/fb_y arithmetic is 10-bit modulo 1024; wrap is permitted and not flagged.
  - An edge that arrives while blocked is dropped, not queued.
  - fb_x, fb_y and fb_dir hold their last values between requests.

Optional Feature:
- POWER_FIREBALL_EN
  - Defined: fireball logic as described above.
  - Undefined:
    - No fire_btn edge detector or cooldown counter.
    - fb_req, fb_x, fb_y and fb_dir tied to 0.
    - FIRE behaves as a plain big state: same hit/shrink rules, char_height=24.

Test Plan:
- RST held 2 cycles, then released -> power_state=0, char_height=12, all other outputs 0 except char_visible=1.
- In SMALL, pulse touch_flower -> next cycle power_state=1, freeze=1; after 30 frame_ticks power_state=2, freeze=0, char_height=24.
- In FIRE, pulse touch_enemy -> power_state=0, invuln=1; char_visible toggles every 4 frames. Enemy pulse at frame 50 is ignored; at frame 120 invuln=0, and the next enemy pulse -> power_state=3, dead=1.
- In SMALL, touch_enemy and touch_flower in the same cycle with invuln=0 -> DEAD, no GROW.
- In FIRE, char_X=5, facing_right=0, press fire_btn -> fb_req pulse, fb_x=1 (wrapped from 1021? no: 5-4=1), fb_dir=0. Second press within 20 frames -> no fb_req. Press with fb_busy=1 -> no fb_req.
- In FIRE, char_X=1020, facing_right=1, fire -> fb_x=8 (1032 mod 1024). Assert RST mid-GROW -> SMALL with timers cleared.

Source files
------------

// File: rtl/mario_power_fsm.sv
// Character power-state FSM: SMALL/GROW/FIRE/DEAD, invulnerability blink and fireball requests.
// Optional fireball spawning is enabled by defining POWER_FIREBALL_EN.
module mario_power_fsm #(
  parameter int unsigned GROW_FRAMES   = 30,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned FIRE_COOLDOWN = 20,
  parameter int unsigned BLINK_PERIOD  = 4
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       frame_tick,
  input  logic       touch_flower,
  input  logic       touch_enemy,
  input  logic       fire_btn,
  input  logic       facing_right,
  input  logic [9:0] char_X,
  input  logic [9:0] char_Y,
  input  logic       fb_busy,
  output logic [1:0] power_state,
  output logic [4:0] char_height,
  output logic       freeze,
  output logic       invuln,
  output logic       char_visible,
  output logic       dead,
  output logic       fb_req,
  output logic [9:0] fb_x,
  output logic [9:0] fb_y,
  output logic       fb_dir
);

  typedef enum logic [1:0] {
    StSmall = 2'd0,
    StGrow  = 2'd1,
    StFire  = 2'd2,
    StDead  = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] grow_q;
  logic [15:0] inv_q;
  logic [15:0] blink_cnt_q;
  logic        phase_q;
  logic        inv_active;
  logic        hit;

  assign inv_active = (inv_q != 16'd0);
  // FIRE shrinks to SMALL on an unprotected enemy touch
  assign hit        = (state_q == StFire) && touch_enemy && !inv_active;

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      state_q     <= StSmall;
      grow_q      <= 16'd0;
      inv_q       <= 16'd0;
      blink_cnt_q <= 16'd0;
      phase_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StSmall: begin
          if (touch_enemy && !inv_active) begin
            state_q <= StDead;
          end else if (touch_flower) begin
            state_q <= StGrow;
            grow_q  <= 16'(GROW_FRAMES);
          end
        end
        StGrow: begin
          if (frame_tick) begin
            if (grow_q <= 16'd1) begin
              state_q <= StFire;
              grow_q  <= 16'd0;
            end else begin
              grow_q <= grow_q - 16'd1;
            end
          end
        end
        StFire: begin
          if (hit) state_q <= StSmall;
        end
        default: ;
      endcase

      // Invulnerability and blink are frozen during GROW
      if (hit) begin
        inv_q       <= 16'(INVULN_FRAMES);
        blink_cnt_q <= 16'd0;
        phase_q     <= 1'b0;
      end else if (frame_tick && inv_active && (state_q != StGrow)) begin
        inv_q <= inv_q - 16'd1;
        if (inv_q == 16'd1) begin
          blink_cnt_q <= 16'd0;
          phase_q     <= 1'b0;
        end else if (blink_cnt_q >= 16'(BLINK_PERIOD - 1)) begin
          blink_cnt_q <= 16'd0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 16'd1;
        end
      end
    end
  end

`ifdef POWER_FIREBALL_EN
  logic        fire_q;
  logic [15:0] cool_q;
  logic        fb_fire;
  logic        fb_req_q;
  logic [9:0]  fb_x_q;
  logic [9:0]  fb_y_q;
  logic        fb_dir_q;

  assign fb_fire = (state_q == StFire) && !hit && fire_btn && !fire_q &&
                   (cool_q == 16'd0) && !fb_busy;

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      fire_q   <= 1'b0;
      cool_q   <= 16'd0;
      fb_req_q <= 1'b0;
      fb_x_q   <= 10'd0;
      fb_y_q   <= 10'd0;
      fb_dir_q <= 1'b0;
    end else begin
      fire_q   <= fire_btn;
      fb_req_q <= fb_fire;
      if (hit) begin
        cool_q <= 16'd0;
      end else if (fb_fire) begin
        cool_q <= 16'(FIRE_COOLDOWN);
      end else if (frame_tick && (cool_q != 16'd0)) begin
        cool_q <= cool_q - 16'd1;
      end
      if (fb_fire) begin
        fb_x_q   <= facing_right ? (char_X + 10'd12) : (char_X - 10'd4);
        fb_y_q   <= char_Y + 10'd4;
        fb_dir_q <= facing_right;
      end
    end
  end

  assign fb_req = fb_req_q;
  assign fb_x   = fb_x_q;
  assign fb_y   = fb_y_q;
  assign fb_dir = fb_dir_q;
`else
  logic unused_fb_inputs;
  assign unused_fb_inputs = ^{fire_btn, facing_right, char_X, char_Y, fb_busy};
  assign fb_req = 1'b0;
  assign fb_x   = 10'd0;
  assign fb_y   = 10'd0;
  assign fb_dir = 1'b0;
`endif

  always_comb begin
    power_state  = state_q;
    char_height  = ((state_q == StGrow) || (state_q == StFire)) ? 5'd24 : 5'd12;
    freeze       = (state_q == StGrow);
    invuln       = inv_active;
    char_visible = (state_q == StDead) || !(inv_active && phase_q);
    dead         = (state_q == StDead);
  end

endmodule

// File: tb/tb_mario_power_fsm.sv
// Directed bench for mario_power_fsm; fireball checks follow POWER_FIREBALL_EN.
module tb_mario_power_fsm;

  logic       sys_clk = 1'b0;
  logic       RST = 1'b0;
  logic       frame_tick = 1'b0;
  logic       touch_flower = 1'b0;
  logic       touch_enemy = 1'b0;
  logic       fire_btn = 1'b0;
  logic       facing_right = 1'b0;
  logic [9:0] char_X = 10'd0;
  logic [9:0] char_Y = 10'd0;
  logic       fb_busy = 1'b0;
  logic [1:0] power_state;
  logic [4:0] char_height;
  logic       freeze;
  logic       invuln;
  logic       char_visible;
  logic       dead;
  logic       fb_req;
  logic [9:0] fb_x;
  logic [9:0] fb_y;
  logic       fb_dir;

  int errors = 0;
  int checks = 0;

  mario_power_fsm dut (
    .sys_clk      (sys_clk),
    .RST          (RST),
    .frame_tick   (frame_tick),
    .touch_flower (touch_flower),
    .touch_enemy  (touch_enemy),
    .fire_btn     (fire_btn),
    .facing_right (facing_right),
    .char_X       (char_X),
    .char_Y       (char_Y),
    .fb_busy      (fb_busy),
    .power_state  (power_state),
    .char_height  (char_height),
    .freeze       (freeze),
    .invuln       (invuln),
    .char_visible (char_visible),
    .dead         (dead),
    .fb_req       (fb_req),
    .fb_x         (fb_x),
    .fb_y         (fb_y),
    .fb_dir       (fb_dir)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      cycle();
    end
  endtask

  task automatic pulse(input logic flower, input logic enemy);
    touch_flower = flower;
    touch_enemy  = enemy;
    cycle();
    touch_flower = 1'b0;
    touch_enemy  = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cycle();
    cycle();
    RST = 1'b0;
    checks++;
    if ({power_state, char_height, freeze, invuln, char_visible, dead, fb_req, fb_x, fb_y, fb_dir}
        !== {2'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ps=%0d h=%0d frz=%0b inv=%0b vis=%0b dead=%0b req=%0b x=%0d y=%0d dir=%0b, required ps=0 h=12 vis=1 others 0",
               power_state, char_height, freeze, invuln, char_visible, dead, fb_req, fb_x, fb_y, fb_dir);
    end
  endtask

  task automatic test_grow();
    pulse(1'b1, 1'b0);
    checks++;
    if ({power_state, freeze, char_height} !== {2'd1, 1'b1, 5'd24}) begin
      errors++;
      $display("FAIL grow_entry: ps=%0d frz=%0b h=%0d, required 1 1 24", power_state, freeze, char_height);
    end
    pulse(1'b1, 1'b1);
    tick(29);
    checks++;
    if ({power_state, freeze, invuln} !== {2'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL grow_hold_29: ps=%0d frz=%0b inv=%0b, required 1 1 0", power_state, freeze, invuln);
    end
    tick(1);
    checks++;
    if ({power_state, freeze, char_height} !== {2'd2, 1'b0, 5'd24}) begin
      errors++;
      $display("FAIL grow_to_fire: ps=%0d frz=%0b h=%0d, required 2 0 24", power_state, freeze, char_height);
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (power_state !== 2'd2) begin
      errors++;
      $display("FAIL fire_flower_ignored: ps=%0d, required 2", power_state);
    end
  endtask

`ifdef POWER_FIREBALL_EN
  task automatic test_fireball();
    char_X = 10'd5;
    char_Y = 10'd100;
    facing_right = 1'b0;
    fire_btn = 1'b1;
    cycle();
    checks++;
    if ({fb_req, fb_x, fb_y, fb_dir} !== {1'b1, 10'd1, 10'd104, 1'b0}) begin
      errors++;
      $display("FAIL fb_left: req=%0b x=%0d y=%0d dir=%0b, required 1 1 104 0", fb_req, fb_x, fb_y, fb_dir);
    end
    cycle();
    checks++;
    if (fb_req !== 1'b0) begin
      errors++;
      $display("FAIL fb_one_cycle: req=%0b, required 0", fb_req);
    end
    fire_btn = 1'b0;
    cycle();
    fire_btn = 1'b1;
    cycle();
    checks++;
    if (fb_req !== 1'b0) begin
      errors++;
      $display("FAIL fb_cooldown: req=%0b, required 0", fb_req);
    end
    fire_btn = 1'b0;
    tick(20);
    fb_busy = 1'b1;
    fire_btn = 1'b1;
    cycle();
    checks++;
    if (fb_req !== 1'b0) begin
      errors++;
      $display("FAIL fb_busy_block: req=%0b, required 0", fb_req);
    end
    fire_btn = 1'b0;
    fb_busy = 1'b0;
    cycle();
    char_X = 10'd1020;
    facing_right = 1'b1;
    fire_btn = 1'b1;
    cycle();
    checks++;
    if ({fb_req, fb_x, fb_y, fb_dir} !== {1'b1, 10'd8, 10'd104, 1'b1}) begin
      errors++;
      $display("FAIL fb_right_wrap: req=%0b x=%0d y=%0d dir=%0b, required 1 8 104 1", fb_req, fb_x, fb_y, fb_dir);
    end
    fire_btn = 1'b0;
    char_X = 10'd0;
    facing_right = 1'b0;
    cycle();
    checks++;
    if ({fb_req, fb_x, fb_dir} !== {1'b0, 10'd8, 1'b1}) begin
      errors++;
      $display("FAIL fb_hold: req=%0b x=%0d dir=%0b, required 0 8 1", fb_req, fb_x, fb_dir);
    end
  endtask
`else
  task automatic test_fireball_off();
    char_X = 10'd5;
    char_Y = 10'd100;
    fire_btn = 1'b1;
    cycle();
    checks++;
    if ({fb_req, fb_x, fb_y, fb_dir} !== {1'b0, 10'd0, 10'd0, 1'b0}) begin
      errors++;
      $display("FAIL fb_tied_off: req=%0b x=%0d y=%0d dir=%0b, required all 0", fb_req, fb_x, fb_y, fb_dir);
    end
    fire_btn = 1'b0;
    cycle();
  endtask
`endif

  task automatic test_invuln();
    pulse(1'b0, 1'b1);
    checks++;
    if ({power_state, invuln, char_visible, char_height} !== {2'd0, 1'b1, 1'b1, 5'd12}) begin
      errors++;
      $display("FAIL hit_shrink: ps=%0d inv=%0b vis=%0b h=%0d, required 0 1 1 12",
               power_state, invuln, char_visible, char_height);
    end
    tick(3);
    checks++;
    if (char_visible !== 1'b1) begin
      errors++;
      $display("FAIL blink_3: vis=%0b, required 1", char_visible);
    end
    tick(1);
    checks++;
    if (char_visible !== 1'b0) begin
      errors++;
      $display("FAIL blink_4: vis=%0b, required 0", char_visible);
    end
    tick(4);
    checks++;
    if (char_visible !== 1'b1) begin
      errors++;
      $display("FAIL blink_8: vis=%0b, required 1", char_visible);
    end
    tick(42);
    pulse(1'b0, 1'b1);
    checks++;
    if ({power_state, dead} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL enemy_while_invuln: ps=%0d dead=%0b, required 0 0", power_state, dead);
    end
    tick(69);
    checks++;
    if ({invuln, char_visible} !== {1'b1, 1'b0}) begin
      errors++;
      $display("FAIL invuln_119: inv=%0b vis=%0b, required 1 0", invuln, char_visible);
    end
    tick(1);
    checks++;
    if ({invuln, char_visible} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL invuln_120: inv=%0b vis=%0b, required 0 1", invuln, char_visible);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if ({power_state, dead, char_visible, char_height} !== {2'd3, 1'b1, 1'b1, 5'd12}) begin
      errors++;
      $display("FAIL small_hit_dead: ps=%0d dead=%0b vis=%0b h=%0d, required 3 1 1 12",
               power_state, dead, char_visible, char_height);
    end
    pulse(1'b1, 1'b0);
    fire_btn = 1'b1;
    cycle();
    fire_btn = 1'b0;
    checks++;
    if ({power_state, fb_req, freeze} !== {2'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL dead_sticky: ps=%0d req=%0b frz=%0b, required 3 0 0", power_state, fb_req, freeze);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pulse(1'b1, 1'b1);
    checks++;
    if ({power_state, freeze, dead} !== {2'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL simul_enemy_wins: ps=%0d frz=%0b dead=%0b, required 3 0 1", power_state, freeze, dead);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse(1'b1, 1'b0);
    tick(10);
    do_reset();
    checks++;
    if ({power_state, freeze} !== {2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_grow: ps=%0d frz=%0b, required 0 0", power_state, freeze);
    end
    pulse(1'b1, 1'b0);
    tick(29);
    checks++;
    if (power_state !== 2'd1) begin
      errors++;
      $display("FAIL regrow_full_timer: ps=%0d, required 1", power_state);
    end
    tick(1);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    checks++;
    if ({power_state, invuln} !== {2'd1, 1'b1}) begin
      errors++;
      $display("FAIL invuln_takes_flower: ps=%0d inv=%0b, required 1 1", power_state, invuln);
    end
    tick(5);
    checks++;
    if ({invuln, char_visible} !== {1'b1, 1'b1}) begin
      errors++;
      $display("FAIL invuln_held_in_grow: inv=%0b vis=%0b, required 1 1", invuln, char_visible);
    end
    do_reset();
    checks++;
    if ({power_state, invuln, freeze} !== {2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_invuln: ps=%0d inv=%0b frz=%0b, required 0 0 0", power_state, invuln, freeze);
    end
    pulse(1'b0, 1'b1);
    checks++;
    if (power_state !== 2'd3) begin
      errors++;
      $display("FAIL no_residual_invuln: ps=%0d, required 3", power_state);
    end
  endtask

  initial begin
    test_reset();
    test_grow();
`ifdef POWER_FIREBALL_EN
    test_fireball();
`else
    test_fireball_off();
`endif
    test_invuln();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
